// File: rtl/aibcr3_dcc_dlyline_ctrl.sv
// Calibration controller for the 64-tap DCC delay line: steps a 6-bit tap code from the
// duty-cycle comparator until it dithers. Optional DCC_LOCK_TRACK_EN keeps tracking after lock.
module aibcr3_dcc_dlyline_ctrl #(
  parameter int INIT_CODE    = 32,
  parameter int SETTLE_CYC   = 7,
  parameter int LOCK_TOGGLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cal_en,
  input  logic        dcc_up,
  input  logic        man_en,
  input  logic [5:0]  man_code,
  output logic [5:0]  code,
  output logic [63:0] bk,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_sat
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, STEP, LOCKED} state_t;

  localparam logic [5:0]  INIT_C   = 6'(INIT_CODE);
  localparam logic [7:0]  SETTLE_C = 8'(SETTLE_CYC);
  localparam logic [3:0]  LOCK_C   = 4'(LOCK_TOGGLES);
  localparam logic [63:0] BK_INIT  = 64'd1 << INIT_CODE;

`ifdef DCC_LOCK_TRACK_EN
  // Tracking build never parks in LOCKED; it keeps looping through SETTLE.
  localparam state_t LOCK_STATE = SETTLE;
`else
  localparam state_t LOCK_STATE = LOCKED;
`endif

  state_t      state_reg, state_next;
  logic [5:0]  code_reg, code_next;
  logic [63:0] bk_reg, bk_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  tog_cnt_reg, tog_cnt_next;
  logic [3:0]  sat_cnt_reg, sat_cnt_next;
  logic        dir_now_reg, dir_now_next;
  logic        dir_prev_reg, dir_prev_next;
  logic        first_reg, first_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        sat_reg, sat_next;

  logic        step_blocked;
  logic        step_rev;
  logic [3:0]  tog_inc;
  logic [3:0]  sat_inc;

  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    cnt_next      = cnt_reg;
    tog_cnt_next  = tog_cnt_reg;
    sat_cnt_next  = sat_cnt_reg;
    dir_now_next  = dir_now_reg;
    dir_prev_next = dir_prev_reg;
    first_next    = first_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    sat_next      = sat_reg;

    step_blocked = (dir_now_reg && (code_reg == 6'd63)) || (!dir_now_reg && (code_reg == 6'd0));
    step_rev     = !first_reg && (dir_now_reg != dir_prev_reg);
    tog_inc      = (tog_cnt_reg == 4'hf) ? tog_cnt_reg : tog_cnt_reg + 4'd1;
    sat_inc      = (sat_cnt_reg == 4'hf) ? sat_cnt_reg : sat_cnt_reg + 4'd1;

    if (man_en) begin
      state_next = IDLE;
      code_next  = man_code;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      sat_next   = 1'b0;
    end else if (!cal_en) begin
      state_next = IDLE;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      sat_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          code_next    = INIT_C;
          cnt_next     = SETTLE_C;
          tog_cnt_next = 4'd0;
          sat_cnt_next = 4'd0;
          first_next   = 1'b1;
          busy_next    = 1'b1;
          state_next   = SETTLE;
        end
        SETTLE: begin
          if (cnt_reg == 8'd0) begin
            state_next = SAMPLE;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        SAMPLE: begin
          dir_now_next = dcc_up;
          state_next   = STEP;
        end
        STEP: begin
          dir_prev_next = dir_now_reg;
          first_next    = 1'b0;
          cnt_next      = SETTLE_C;
          state_next    = SETTLE;
          if (step_blocked) begin
            sat_cnt_next = sat_inc;
          end else begin
            sat_cnt_next = 4'd0;
            code_next    = dir_now_reg ? code_reg + 6'd1 : code_reg - 6'd1;
          end
          if (step_rev) begin
            tog_cnt_next = tog_inc;
          end
          // Once locked (only reachable here when tracking) the counters no longer matter.
          if (done_reg) begin
`ifdef DCC_LOCK_TRACK_EN
            sat_next = step_blocked;
`endif
          end else if (tog_cnt_next == LOCK_C) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = LOCK_STATE;
          end else if (sat_cnt_next == LOCK_C) begin
            done_next  = 1'b1;
            sat_next   = 1'b1;
            busy_next  = 1'b0;
            state_next = LOCK_STATE;
          end
        end
        LOCKED: begin
          state_next = LOCKED;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // One-hot decode of the next code so bk and code change on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bk
      assign bk_next[gi] = (code_next == 6'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      code_reg     <= INIT_C;
      bk_reg       <= BK_INIT;
      cnt_reg      <= 8'd0;
      tog_cnt_reg  <= 4'd0;
      sat_cnt_reg  <= 4'd0;
      dir_now_reg  <= 1'b0;
      dir_prev_reg <= 1'b0;
      first_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sat_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      code_reg     <= code_next;
      bk_reg       <= bk_next;
      cnt_reg      <= cnt_next;
      tog_cnt_reg  <= tog_cnt_next;
      sat_cnt_reg  <= sat_cnt_next;
      dir_now_reg  <= dir_now_next;
      dir_prev_reg <= dir_prev_next;
      first_reg    <= first_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      sat_reg      <= sat_next;
    end
  end

  assign code     = code_reg;
  assign bk       = bk_reg;
  assign cal_busy = busy_reg;
  assign cal_done = done_reg;
  assign cal_sat  = sat_reg;

endmodule

// File: tb/tb_aibcr3_dcc_dlyline_ctrl.sv
// Self-checking bench for aibcr3_dcc_dlyline_ctrl: table-driven calibration runs with a
// per-step scoreboard, plus hand-written abort, manual-override and reset sequences.
module tb_aibcr3_dcc_dlyline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cal_en;
  logic        dcc_up;
  logic        man_en;
  logic [5:0]  man_code;
  logic [5:0]  code;
  logic [63:0] bk;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_sat;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic [6:0] target;
    int         exp_steps;
    logic [5:0] exp_code;
    logic       exp_sat;
  } vec_t;

  vec_t vt[4];

  always #5 clk = ~clk;

  aibcr3_dcc_dlyline_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cal_en   (cal_en),
    .dcc_up   (dcc_up),
    .man_en   (man_en),
    .man_code (man_code),
    .code     (code),
    .bk       (bk),
    .cal_busy (cal_busy),
    .cal_done (cal_done),
    .cal_sat  (cal_sat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // bk must be exactly one-hot and point at code on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("bk_popcount", 64'($countones(bk)), 64'd1);
      chk("bk_at_code", 64'(bk[code]), 64'd1);
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cal_en = 1'b0;
    man_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_code(input logic [5:0] v, input int lim);
    int n;
    n = 0;
    while (code !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_code", 64'(code), 64'(v));
  endtask

  // Comparator model: request up while below target. Each step's expected code is queued
  // when dcc_up is driven and checked exactly 10 cycles later.
  task automatic run_cal(input logic [6:0] target, output int steps);
    logic [5:0] c;
    logic [5:0] e;
    c      = 6'd32;
    steps  = 0;
    dcc_up = (7'(c) < target);
    cal_en = 1'b1;
    cycle();
    chk("start_code", 64'(code), 64'd32);
    chk("start_busy", 64'(cal_busy), 64'd1);
    while (steps < 60) begin
      if (dcc_up) e = (c == 6'd63) ? c : c + 6'd1;
      else        e = (c == 6'd0)  ? c : c - 6'd1;
      exp_q.push_back(e);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("no_early_step", 64'(code), 64'(c));
      cycle();
      steps++;
      chk("step_code", 64'(code), 64'(exp_q.pop_front()));
      c = e;
      if (cal_done) break;
      chk("busy_during_cal", 64'(cal_busy), 64'd1);
      dcc_up = (7'(c) < target);
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int steps;
    rst      = 1'b1;
    cal_en   = 1'b0;
    dcc_up   = 1'b0;
    man_en   = 1'b0;
    man_code = 6'd0;

    vt[0] = '{7'd40, 12, 6'd40, 1'b0};
    vt[1] = '{7'd64, 35, 6'd63, 1'b1};
    vt[2] = '{7'd0,  36, 6'd0,  1'b1};
    vt[3] = '{7'd30, 7,  6'd29, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_code", 64'(code), 64'd32);
    chk("rst_bk", bk, 64'h1 << 32);
    chk("rst_busy", 64'(cal_busy), 64'd0);
    chk("rst_done", 64'(cal_done), 64'd0);
    chk("rst_sat", 64'(cal_sat), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_cal(vt[i].target, steps);
      chk("lock_steps", 64'(steps), 64'(vt[i].exp_steps));
      chk("lock_code", 64'(code), 64'(vt[i].exp_code));
      chk("lock_bk", bk, 64'h1 << vt[i].exp_code);
      chk("lock_done", 64'(cal_done), 64'd1);
      chk("lock_sat", 64'(cal_sat), 64'(vt[i].exp_sat));
      chk("lock_busy", 64'(cal_busy), 64'd0);
      $display("vec %0d target=%0d steps=%0d code=%0d done=%0b sat=%0b",
               i, vt[i].target, steps, code, cal_done, cal_sat);
`ifndef DCC_LOCK_TRACK_EN
      dcc_up = ~dcc_up;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("hold_code", 64'(code), 64'(vt[i].exp_code));
      chk("hold_done", 64'(cal_done), 64'd1);
`endif
      cal_en = 1'b0;
      cycle();
      chk("abort_done", 64'(cal_done), 64'd0);
      chk("abort_sat", 64'(cal_sat), 64'd0);
      chk("abort_code", 64'(code), 64'(vt[i].exp_code));
    end

    // Manual override clears a lock.
    do_reset();
    run_cal(7'd40, steps);
    man_code = 6'd9;
    man_en   = 1'b1;
    cycle();
    chk("man_after_lock_code", 64'(code), 64'd9);
    chk("man_after_lock_done", 64'(cal_done), 64'd0);
    $display("seq man_after_lock code=%0d done=%0b", code, cal_done);

    // Abort mid-SETTLE at code 45, then restart.
    do_reset();
    dcc_up = 1'b1;
    cal_en = 1'b1;
    wait_code(6'd45, 200);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cal_en = 1'b0;
    cycle();
    chk("abort_mid_code", 64'(code), 64'd45);
    chk("abort_mid_busy", 64'(cal_busy), 64'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("abort_held_code", 64'(code), 64'd45);
    cal_en = 1'b1;
    cycle();
    chk("restart_code", 64'(code), 64'd32);
    chk("restart_busy", 64'(cal_busy), 64'd1);
    $display("seq abort_restart code=%0d busy=%0b", code, cal_busy);

    // Manual override landing in STEP.
    wait_code(6'd33, 20);
    repeat (9) @(posedge clk);
    @(negedge clk);
    man_code = 6'd5;
    man_en   = 1'b1;
    cycle();
    chk("man_step_code", 64'(code), 64'd5);
    chk("man_step_bk", bk, 64'h20);
    chk("man_step_done", 64'(cal_done), 64'd0);
    chk("man_step_busy", 64'(cal_busy), 64'd0);
    man_code = 6'd17;
    cycle();
    chk("man_follow_code", 64'(code), 64'd17);
    man_en = 1'b0;
    cal_en = 1'b0;
    repeat (3) cycle();
    chk("man_release_hold", 64'(code), 64'd17);
    cal_en = 1'b1;
    cycle();
    chk("man_release_restart", 64'(code), 64'd32);
    $display("seq manual code=%0d", code);

    // Reset asserted while in STEP.
    wait_code(6'd33, 20);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("rst_step_code", 64'(code), 64'd32);
    chk("rst_step_bk", bk, 64'h1 << 32);
    chk("rst_step_busy", 64'(cal_busy), 64'd0);
    rst    = 1'b0;
    cal_en = 1'b0;
    $display("seq rst_in_step code=%0d", code);

`ifdef DCC_LOCK_TRACK_EN
    do_reset();
    run_cal(7'd40, steps);
    chk("track_lock_code", 64'(code), 64'd40);
    dcc_up = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("track_code", 64'(code), 64'(40 + k));
      chk("track_done", 64'(cal_done), 64'd1);
      chk("track_busy", 64'(cal_busy), 64'd0);
      $display("seq track step %0d code=%0d", k, code);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
